// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and register map for the PWM configuration arbiter
package cfg_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_WRITE
  } arb_state_t;

  localparam int REG_EN_OUT_LO = 0;
  localparam int REG_EN_OUT_HI = 1;
  localparam int REG_EN_PWM_LO = 2;
  localparam int REG_EN_PWM_HI = 3;
  localparam int REG_PWM_DUTY  = 4;
  localparam int NUM_CFG_REGS  = 5;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       ack,
  output logic [1:0] gnt
);

  // last_q holds the index granted on the most recent completed handshake
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (ack && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Reset to "req 1 granted last" so req 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// rtl/cfg_reg_arbiter.sv - arbitrated shadow/live configuration bank with period-aligned commit
module cfg_reg_arbiter
  import cfg_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int MAX_ADDRESS = 4,
  parameter int COMMIT_SYNC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_wr_valid,
  output logic              spi_wr_ready,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              seq_wr_valid,
  output logic              seq_wr_ready,
  input  logic [ADDR_W-1:0] seq_wr_addr,
  input  logic [DATA_W-1:0] seq_wr_data,
  input  logic              pwm_period_end,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_err,
  output logic              cfg_pending
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dirty_q, dirty_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] shadow_q [NUM_CFG_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_CFG_REGS];
  logic [DATA_W-1:0] live_q   [NUM_CFG_REGS];
  logic [DATA_W-1:0] live_d   [NUM_CFG_REGS];

  logic [1:0] gnt;
  logic       ack;
  logic       dirty_set;
  logic       commit;
  logic       in_range;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({seq_wr_valid, spi_wr_valid}),
    .ack (ack),
    .gnt (gnt)
  );

  assign in_range     = (addr_q <= ADDR_W'(MAX_ADDRESS));
  assign spi_wr_ready = !rst && (state_q == ARB_IDLE) && gnt[0];
  assign seq_wr_ready = !rst && (state_q == ARB_IDLE) && gnt[1];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    shadow_d  = shadow_q;
    dirty_set = 1'b0;
    wr_err_d  = 1'b0;
    ack       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt != 2'b00) begin
          ack     = !rst;
          state_d = ARB_WRITE;
          if (gnt[1]) begin
            addr_d = seq_wr_addr;
            data_d = seq_wr_data;
          end else begin
            addr_d = spi_wr_addr;
            data_d = spi_wr_data;
          end
        end
      end
      ARB_WRITE: begin
        state_d = ARB_IDLE;
        if (in_range) begin
          dirty_set = 1'b1;
          for (int i = 0; i < NUM_CFG_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
              shadow_d[i] = data_q;
            end
          end
        end else begin
          wr_err_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Commit copies the shadow as it stood before this cycle's write; a
  // simultaneous write keeps dirty set so it goes out on the next commit.
  always_comb begin
    live_d = live_q;
    if (COMMIT_SYNC != 0) begin
      commit = pwm_period_end && dirty_q;
    end else begin
      commit = dirty_q;
    end
    if (commit) begin
      live_d = shadow_q;
    end
    dirty_d = dirty_set || (dirty_q && !commit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      dirty_q  <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      dirty_q  <= dirty_d;
      wr_err_q <= wr_err_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign en_reg_out_7_0  = live_q[REG_EN_OUT_LO];
  assign en_reg_out_15_8 = live_q[REG_EN_OUT_HI];
  assign en_reg_pwm_7_0  = live_q[REG_EN_PWM_LO];
  assign en_reg_pwm_15_8 = live_q[REG_EN_PWM_HI];
  assign pwm_duty_cycle  = live_q[REG_PWM_DUTY];
  assign wr_err          = wr_err_q;
  assign cfg_pending     = dirty_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb/tb_cfg_reg_arbiter.sv - table-driven bench for cfg_reg_arbiter
module tb_cfg_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_wr_valid, seq_wr_valid, pwm_period_end;
  logic [6:0] spi_wr_addr, seq_wr_addr;
  logic [7:0] spi_wr_data, seq_wr_data;

  logic       spi_wr_ready, seq_wr_ready, wr_err, cfg_pending;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  logic       a_spi_rdy, a_seq_rdy, a_err, a_pend;
  logic [7:0] a_r0, a_r1, a_r2, a_r3, a_r4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_reg_arbiter #(.COMMIT_SYNC(1)) dut (
    .clk(clk), .rst(rst),
    .spi_wr_valid(spi_wr_valid), .spi_wr_ready(spi_wr_ready),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .seq_wr_valid(seq_wr_valid), .seq_wr_ready(seq_wr_ready),
    .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
    .pwm_period_end(pwm_period_end),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_err(wr_err), .cfg_pending(cfg_pending)
  );

  cfg_reg_arbiter #(.COMMIT_SYNC(0)) dut_async (
    .clk(clk), .rst(rst),
    .spi_wr_valid(spi_wr_valid), .spi_wr_ready(a_spi_rdy),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .seq_wr_valid(seq_wr_valid), .seq_wr_ready(a_seq_rdy),
    .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
    .pwm_period_end(pwm_period_end),
    .en_reg_out_7_0(a_r0), .en_reg_out_15_8(a_r1),
    .en_reg_pwm_7_0(a_r2), .en_reg_pwm_15_8(a_r3),
    .pwm_duty_cycle(a_r4), .wr_err(a_err), .cfg_pending(a_pend)
  );

  typedef struct {
    logic       rst;
    logic       sv;
    logic [6:0] sa;
    logic [7:0] sd;
    logic       qv;
    logic [6:0] qa;
    logic [7:0] qd;
    logic       pe;
    logic       e_sr;
    logic       e_qr;
    logic       e_err;
    logic       e_pend;
    logic [7:0] e0, e1, e2, e3, e4;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                     input logic qv, input logic [6:0] qa, input logic [7:0] qd, input logic pe,
                     input logic sr, input logic qr, input logic er, input logic pd,
                     input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [7:0] e3, input logic [7:0] e4);
    vec_t v;
    v.rst = r; v.sv = sv; v.sa = sa; v.sd = sd; v.qv = qv; v.qa = qa; v.qd = qd; v.pe = pe;
    v.e_sr = sr; v.e_qr = qr; v.e_err = er; v.e_pend = pd;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                       input logic qv, input logic [6:0] qa, input logic [7:0] qd, input logic pe);
    rst = r; spi_wr_valid = sv; spi_wr_addr = sa; spi_wr_data = sd;
    seq_wr_valid = qv; seq_wr_addr = qa; seq_wr_data = qd; pwm_period_end = pe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    tick();
    tick();

    //   rst sv  sa     sd     qv  qa     qd     pe  | sr qr er pd | out_lo out_hi pwm_lo pwm_hi duty
    add(1, 1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 0,  1, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    add(1, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h00, 8'hAA, 1, 7'h01, 8'h55, 0,  1, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 1, 7'h01, 8'h55, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 1, 7'h01, 8'h55, 0,  0, 1, 0, 1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h05, 8'h11, 0, 7'h00, 8'h00, 0,  1, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 1, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 1, 7'h7F, 8'h22, 0,  0, 1, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 1, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h02, 8'h0F, 0, 7'h00, 8'h00, 0,  1, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h00, 8'h3C, 0, 7'h00, 8'h00, 0,  1, 0, 0, 1,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1,  8'hAA, 8'h55, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1,  8'hAA, 8'h55, 8'h0F, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h3C, 8'h55, 8'h0F, 8'h00, 8'h00);
    add(0, 1, 7'h02, 8'h0F, 0, 7'h00, 8'h00, 0,  1, 0, 0, 0,  8'h3C, 8'h55, 8'h0F, 8'h00, 8'h00);
    add(1, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h3C, 8'h55, 8'h0F, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 1, 7'h02, 8'h0F, 0, 7'h00, 8'h00, 0,  1, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1,  0, 0, 0, 1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0,  0, 0, 0, 0,  8'h00, 8'h00, 8'h0F, 8'h00, 8'h00);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].qv, tbl[i].qa, tbl[i].qd, tbl[i].pe);
      @(negedge clk);
      chk($sformatf("v%0d.spi_rdy", i), 32'(spi_wr_ready), 32'(tbl[i].e_sr));
      chk($sformatf("v%0d.seq_rdy", i), 32'(seq_wr_ready), 32'(tbl[i].e_qr));
      chk($sformatf("v%0d.wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d.pending", i), 32'(cfg_pending), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d.out_lo", i), 32'(en_reg_out_7_0), 32'(tbl[i].e0));
      chk($sformatf("v%0d.out_hi", i), 32'(en_reg_out_15_8), 32'(tbl[i].e1));
      chk($sformatf("v%0d.pwm_lo", i), 32'(en_reg_pwm_7_0), 32'(tbl[i].e2));
      chk($sformatf("v%0d.pwm_hi", i), 32'(en_reg_pwm_15_8), 32'(tbl[i].e3));
      chk($sformatf("v%0d.duty", i), 32'(pwm_duty_cycle), 32'(tbl[i].e4));
      tick();
    end

    // Both requesters held valid: grants alternate, one write per two cycles
    drive(1'b1, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 7'h03, 8'h01, 1'b1, 7'h03, 8'h02, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.spi_rdy", k), 32'(spi_wr_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d.seq_rdy", k), 32'(seq_wr_ready), (k % 4 == 2) ? 32'd1 : 32'd0);
      tick();
    end

    // Last write (seq, 0x02) completes; immediate-commit instance follows without a strobe
    drive(1'b0, 1'b0, 7'h0, 8'h0, 1'b0, 7'h0, 8'h0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    chk("sync.pwm_hi_held", 32'(en_reg_pwm_15_8), 32'h00);
    chk("sync.pending", 32'(cfg_pending), 32'd1);
    chk("async.pwm_hi", 32'(a_r3), 32'h02);
    chk("async.pending", 32'(a_pend), 32'd0);
    pwm_period_end = 1'b1;
    tick();
    pwm_period_end = 1'b0;
    @(negedge clk);
    chk("sync.pwm_hi_commit", 32'(en_reg_pwm_15_8), 32'h02);
    chk("sync.pending_clr", 32'(cfg_pending), 32'd0);
    chk("async.pwm_hi_keep", 32'(a_r3), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
